// File: rtl/piezo_tone_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piezo_tone_driver_if : note-code bus from the playback logic to the driver
// Revision 1.0
// ---------------------------------------------------------------------------
interface piezo_tone_driver_if;
  logic [3:0] note_code;
  logic       mute;

  modport master (output note_code, output mute);
  modport slave  (input  note_code, input  mute);
endinterface
`default_nettype wire

// File: rtl/piezo_tone_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piezo_tone_driver : note code -> glitch-free square wave plus one-hot LED bar
// Revision 1.0
// ---------------------------------------------------------------------------
module piezo_tone_driver #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  piezo_tone_driver_if.slave         note_if,
  output logic                       piezo,
  output logic [7:0]                 led_out,
  output logic                       note_active,
  output logic                       code_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  cur_q, cur_d;
  logic [3:0]  code_q, code_d;
  logic        phase_q, phase_d;
  logic        code_err_q, code_err_d;
  logic        piezo_q, piezo_d;
  logic [7:0]  led_q, led_d;
  logic        active_q, active_d;
  logic        code_valid;
  logic        run_d;
  logic [19:0] half_cur;

  function automatic logic [19:0] half_of(input logic [3:0] code);
    case (code)
      4'd1:    half_of = 20'(CLK_HZ / (2 * 262));
      4'd2:    half_of = 20'(CLK_HZ / (2 * 294));
      4'd3:    half_of = 20'(CLK_HZ / (2 * 330));
      4'd4:    half_of = 20'(CLK_HZ / (2 * 349));
      4'd5:    half_of = 20'(CLK_HZ / (2 * 392));
      4'd6:    half_of = 20'(CLK_HZ / (2 * 440));
      4'd7:    half_of = 20'(CLK_HZ / (2 * 494));
      4'd8:    half_of = 20'(CLK_HZ / (2 * 523));
      default: half_of = 20'd1;
    endcase
  endfunction

  always_comb begin
    code_valid = (note_if.note_code <= 4'd8);
    code_d     = code_valid ? note_if.note_code : 4'd0;
    code_err_d = code_err_q | ~code_valid;
    half_cur   = half_of(cur_q);

    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    phase_d = phase_q;

    case (state_q)
      IDLE: begin
        cnt_d   = 20'd0;
        phase_d = 1'b0;
        if (code_q != 4'd0) begin
          state_d = RUN;
          cur_d   = code_q;
          phase_d = 1'b1;
        end
      end
      RUN: begin
        // code_q is only looked at on the last cycle of a half-period
        if (cnt_q == half_cur - 20'd1) begin
          cnt_d = 20'd0;
          if (code_q == 4'd0) begin
            state_d = IDLE;
            phase_d = 1'b0;
            cur_d   = 4'd0;
          end else begin
            cur_d   = code_q;
            phase_d = ~phase_q;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    run_d    = (state_d == RUN);
    active_d = run_d;
    piezo_d  = phase_d & ~note_if.mute & run_d;
    led_d    = run_d ? (8'b1 << (cur_d - 4'd1)) : 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 20'd0;
      cur_q      <= 4'd0;
      code_q     <= 4'd0;
      phase_q    <= 1'b0;
      code_err_q <= 1'b0;
      piezo_q    <= 1'b0;
      led_q      <= 8'd0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      code_q     <= code_d;
      phase_q    <= phase_d;
      code_err_q <= code_err_d;
      piezo_q    <= piezo_d;
      led_q      <= led_d;
      active_q   <= active_d;
    end
  end

  assign piezo       = piezo_q;
  assign led_out     = led_q;
  assign note_active = active_q;
  assign code_err    = code_err_q;

endmodule
`default_nettype wire

// File: tb/tb_piezo_tone_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_piezo_tone_driver : scoreboard bench for piezo_tone_driver at CLK_HZ=5240
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_piezo_tone_driver;
  localparam int CLK_HZ = 5240;

  typedef struct packed {
    logic       piezo;
    logic [7:0] led;
    logic       act;
    logic       err;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       piezo;
  logic [7:0] led_out;
  logic       note_active;
  logic       code_err;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];

  piezo_tone_driver_if nif ();

  piezo_tone_driver #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .reset      (reset),
    .note_if    (nif.slave),
    .piezo      (piezo),
    .led_out    (led_out),
    .note_active(note_active),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  function automatic int half_cycles(input int n);
    int freq [8] = '{262, 294, 330, 349, 392, 440, 494, 523};
    return CLK_HZ / (2 * freq[n-1]);
  endfunction

  // Reference: note sounding, which half we are in, cycles left in that half
  initial begin
    int  m_code = 0;
    bit  m_play = 0;
    int  m_note = 0;
    bit  m_high = 0;
    int  m_left = 0;
    bit  m_err  = 0;
    int  prev;
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_code = 0; m_play = 0; m_note = 0; m_high = 0; m_left = 0; m_err = 0;
        sb.delete();
      end else begin
        prev = m_code;
        if (!m_play) begin
          if (prev != 0) begin
            m_play = 1; m_note = prev; m_high = 1; m_left = half_cycles(prev);
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (prev == 0) begin
              m_play = 0; m_high = 0;
            end else begin
              m_note = prev; m_high = !m_high; m_left = half_cycles(prev);
            end
          end
        end
        if (int'(nif.note_code) > 8) begin
          m_code = 0; m_err = 1;
        end else begin
          m_code = int'(nif.note_code);
        end
        e.piezo = m_play && m_high && !nif.mute;
        e.led   = m_play ? 8'(1 << (m_note - 1)) : 8'h00;
        e.act   = m_play;
        e.err   = m_err;
        sb.push_back(e);
      end
    end
  end

  // Monitor: one comparison per cycle, half a period after the edge
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      got = {piezo, led_out, note_active, code_err};
      if (!reset) begin
        n_checks++;
        if (got !== '0) begin
          n_errors++;
          $display("FAIL in_reset t=%0t: got piezo=%0b led=%02h act=%0b err=%0b, need all zero",
                   $time, piezo, led_out, note_active, code_err);
        end
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL outputs t=%0t: got piezo=%0b led=%02h act=%0b err=%0b, need piezo=%0b led=%02h act=%0b err=%0b",
                   $time, piezo, led_out, note_active, code_err, e.piezo, e.led, e.act, e.err);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play(input logic [3:0] code, input int n);
    nif.note_code = code;
    cycles(n);
  endtask

  initial begin
    int r;
    nif.note_code = 4'd0;
    nif.mute      = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(2);

    // start and stop on C4
    play(4'd1, 100);
    play(4'd0, 30);

    // note change somewhere inside a half
    play(4'd1, 40 + $urandom_range(0, 9));
    play(4'd5, 60);
    play(4'd0, 30);

    // short D4 pulse while C5 plays
    play(4'd8, 21);
    play(4'd2, 2);
    play(4'd8, 30);
    play(4'd0, 20);

    // invalid code from idle, then E4
    play(4'd12, 5);
    play(4'd3, 50);
    play(4'd0, 20);

    // mute window
    play(4'd3, 15);
    nif.mute = 1'b1;
    cycles(20);
    nif.mute = 1'b0;
    cycles(30);
    play(4'd0, 20);

    // asynchronous reset while piezo is high
    play(4'd8, 12);
    for (int i = 0; i < 20 && !piezo; i++) cycles(1);
    n_checks++;
    if (piezo !== 1'b1) begin
      n_errors++;
      $display("FAIL wait_high: got piezo=%0b, need 1 within 20 cycles", piezo);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({piezo, led_out, note_active, code_err} !== 11'd0) begin
      n_errors++;
      $display("FAIL async_reset: got piezo=%0b led=%02h act=%0b err=%0b, need all zero",
               piezo, led_out, note_active, code_err);
    end
    cycles(3);
    reset = 1'b1;
    cycles(40);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r < 4)       nif.note_code = 4'd0;
      else if (r < 17) nif.note_code = 4'($urandom_range(1, 8));
      else             nif.note_code = 4'($urandom_range(9, 15));
      nif.mute = ($urandom_range(0, 9) == 0);
      cycles($urandom_range(1, 25));
    end
    nif.mute = 1'b0;
    play(4'd0, 30);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
